// File: rtl/reg_file_loader_pkg.sv
// Shared definitions for the register-file nibble loader.
// State codes and nibble width used by the loader and its shifter.
package reg_file_loader_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ENTRY  = 2'd0;
  localparam state_t COMMIT = 2'd1;
  localparam state_t HOLD   = 2'd2;
endpackage

// File: rtl/reg_file_loader_nibble_shifter.sv
// Word assembly register for the loader.
// Shifts hex digits in MSB-first, clears, or restarts from one digit.
module nibble_shifter
  import reg_file_loader_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                shift,
  input  logic                load,
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [DW-1:0]       ds
);

  // Clear wins over shift, shift over single-digit restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds <= '0;
    end else if (clr) begin
      ds <= '0;
    end else if (shift) begin
      ds <= {ds[DW-NIBBLE_W-1:0], nibble};
    end else if (load) begin
      ds <= {{(DW-NIBBLE_W){1'b0}}, nibble};
    end
  end

endmodule

// File: rtl/reg_file_loader.sv
// Hex-keypad style register-file writer.
// Collects ND nibbles, then pulses WE once with the sampled address.
module reg_file_loader
  import reg_file_loader_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step,
  input  logic                     abort,
  input  logic [3:0]               nibble_in,
  input  logic [AW-1:0]            adr_in,
  output logic [DW-1:0]            DS,
  output logic [AW-1:0]            W_Adr,
  output logic                     WE,
  output logic [$clog2(DW/4+1)-1:0] digit_cnt,
  output logic                     busy
);

  localparam int ND = DW / 4;
  localparam int CW = $clog2(ND + 1);

  state_t state;
  logic   clr;
  logic   shift;
  logic   load;
  logic   last;

  assign last = (digit_cnt == CW'(ND - 1));

  // Shifter controls; abort always beats step, COMMIT ignores both.
  always_comb begin
    clr   = 1'b0;
    shift = 1'b0;
    load  = 1'b0;
    case (state)
      ENTRY: begin
        clr   = abort;
        shift = step & ~abort;
      end
      HOLD: begin
        clr  = abort;
        load = step & ~abort;
      end
      default: ;
    endcase
  end

  nibble_shifter #(.DW(DW)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .shift  (shift),
    .load   (load),
    .nibble (nibble_in),
    .ds     (DS)
  );

  // Entry FSM: digit count, address capture and the one-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ENTRY;
      digit_cnt <= '0;
      W_Adr     <= '0;
      WE        <= 1'b0;
    end else begin
      WE <= 1'b0;
      case (state)
        ENTRY: begin
          if (abort) begin
            digit_cnt <= '0;
          end else if (step) begin
            digit_cnt <= digit_cnt + CW'(1);
            if (last) begin
              W_Adr <= adr_in;
              WE    <= 1'b1;
              state <= COMMIT;
            end
          end
        end
        COMMIT: state <= HOLD;
        HOLD: begin
          if (abort) begin
            digit_cnt <= '0;
            state     <= ENTRY;
          end else if (step) begin
            digit_cnt <= CW'(1);
            state     <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  // Decoded from registers only.
  assign busy = (state == COMMIT) ||
                ((state == ENTRY) && (digit_cnt != '0));

endmodule

// File: tb/tb_reg_file_loader.sv
// Scoreboard bench for reg_file_loader.
// Digit-list reference model plus directed and random stimulus.
module tb_reg_file_loader;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int ND = DW / 4;
  localparam int CW = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          step = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    nibble_in = '0;
  logic [AW-1:0] adr_in = '0;
  logic [DW-1:0] DS;
  logic [AW-1:0] W_Adr;
  logic          WE;
  logic [CW-1:0] digit_cnt;
  logic          busy;

  reg_file_loader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .abort     (abort),
    .nibble_in (nibble_in),
    .adr_in    (adr_in),
    .DS        (DS),
    .W_Adr     (W_Adr),
    .WE        (WE),
    .digit_cnt (digit_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: the word is the list of digits entered so far.
  int            m_digits[$];
  bit            m_writing = 0;
  bit            m_shown = 0;
  logic [AW-1:0] m_adr = '0;
  logic [AW+DW-1:0] sb[$];

  function automatic logic [DW-1:0] word_of();
    logic [DW-1:0] w = '0;
    foreach (m_digits[i]) w = (w << 4) | DW'(m_digits[i]);
    return w;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_digits.delete();
      m_writing = 0;
      m_shown = 0;
      m_adr = '0;
    end else if (m_writing) begin
      m_writing = 0;
      m_shown = 1;
    end else if (abort) begin
      m_digits.delete();
      m_shown = 0;
    end else if (step) begin
      if (m_shown) begin
        m_digits.delete();
        m_shown = 0;
      end
      m_digits.push_back(int'(nibble_in));
      if (m_digits.size() == ND) begin
        m_adr = adr_in;
        m_writing = 1;
        sb.push_back({adr_in, word_of()});
      end
    end
  end

  // Monitor: compare visible state each cycle, pop on every write.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [AW+DW-1:0] e;
      chk("ds", 32'(DS), 32'(word_of()));
      chk("digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
      chk("busy", 32'(busy),
          32'(m_writing || (!m_shown && m_digits.size() > 0)));
      chk("we", 32'(WE), 32'(m_writing));
      if (WE) begin
        if (sb.size() == 0) begin
          chk("we_unexpected", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("w_adr", 32'(W_Adr), 32'(e[AW+DW-1:DW]));
          chk("w_data", 32'(DS), 32'(e[DW-1:0]));
        end
      end
    end
  end

  task automatic tick(input bit st, input bit ab, input logic [3:0] nb,
                      input logic [AW-1:0] ad, input bit rs);
    @(negedge clk);
    step = st;
    abort = ab;
    nibble_in = nb;
    adr_in = ad;
    reset = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 4'h0, adr_in, 0);
  endtask

  task automatic enter(input logic [15:0] w, input logic [AW-1:0] ad);
    for (int i = ND - 1; i >= 0; i--) begin
      tick(1, 0, w[i*4 +: 4], ad, 0);
      idle(1);
    end
  endtask

  initial begin
    tick(0, 0, 4'h0, '0, 1);
    tick(0, 0, 4'h0, '0, 1);
    tick(0, 0, 4'h0, 3'd3, 0);
    idle(1);
    chk("rst_ds", 32'(DS), 32'h0);
    chk("rst_we", 32'(WE), 32'h0);
    chk("rst_cnt", 32'(digit_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    mon_en = 1'b1;

    enter(16'hAA55, 3'd3);
    idle(2);
    chk("basic_ds", 32'(DS), 32'hAA55);
    chk("basic_adr", 32'(W_Adr), 32'd3);
    chk("basic_busy", 32'(busy), 32'h0);

    tick(1, 0, 4'h1, 3'd1, 0);
    tick(1, 0, 4'h2, 3'd1, 0);
    tick(0, 1, 4'h0, 3'd1, 0);
    idle(1);
    chk("abort_ds", 32'(DS), 32'h0);
    chk("abort_cnt", 32'(digit_cnt), 32'h0);
    enter(16'hF00D, 3'd5);
    idle(2);
    chk("f00d_ds", 32'(DS), 32'hF00D);

    tick(1, 0, 4'h7, 3'd4, 0);
    tick(1, 0, 4'h8, 3'd4, 0);
    tick(1, 1, 4'h9, 3'd4, 0);
    idle(1);
    chk("both_ds", 32'(DS), 32'h0);
    chk("both_cnt", 32'(digit_cnt), 32'h0);

    tick(1, 0, 4'hC, 3'd7, 0);
    tick(1, 0, 4'h0, 3'd7, 0);
    tick(1, 0, 4'hF, 3'd7, 0);
    tick(1, 0, 4'hE, 3'd2, 0);
    tick(1, 0, 4'h3, 3'd6, 0);
    idle(2);
    chk("commit_step_ds", 32'(DS), 32'hC0FE);
    chk("late_adr", 32'(W_Adr), 32'd2);

    tick(1, 0, 4'h1, 3'd1, 0);
    tick(1, 0, 4'h2, 3'd1, 0);
    tick(1, 0, 4'h3, 3'd1, 0);
    tick(1, 0, 4'h4, 3'd1, 1);
    tick(0, 0, 4'h0, 3'd1, 0);
    chk("rst_mid_we", 32'(WE), 32'h0);
    chk("rst_mid_ds", 32'(DS), 32'h0);
    chk("rst_mid_adr", 32'(W_Adr), 32'h0);
    chk("rst_mid_cnt", 32'(digit_cnt), 32'h0);

    enter(16'h1234, 3'd6);
    idle(2);
    tick(1, 0, 4'h9, 3'd0, 0);
    idle(1);
    chk("reentry_ds", 32'(DS), 32'h0009);
    chk("reentry_cnt", 32'(digit_cnt), 32'd1);
    chk("reentry_busy", 32'(busy), 32'd1);

    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0,
           4'($urandom), AW'($urandom), $urandom_range(0, 99) == 0);
    end
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
